// File: rtl/receiver_pkg.sv
// Shared types and defaults for the oversampling serial receiver.
package receiver_pkg;

  localparam int DEF_CLKS_PER_BIT = 8;
  localparam int DEF_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

endpackage

// File: rtl/receiver_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module rx_sync (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/receiver.sv
// Serial frame receiver: mid-bit sampling of a start/data/stop frame, LSB first,
// presenting each good byte with a REQ/ACK handshake.
module receiver
  import receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 RCV,
  input  logic                 RCV_ACK,
  output logic                 RCV_REQ,
  output logic [DATA_BITS-1:0] RCV_DATA
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic line;

  rx_sync u_sync (
    .clk (clk),
    .clr (clr),
    .d   (RCV),
    .q   (line)
  );

  state_t                state_reg, state_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [DATA_BITS-1:0]  shift_reg, shift_next;
  logic [DATA_BITS-1:0]  data_reg, data_next;
  logic                  req_reg, req_next;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      req_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      req_reg   <= req_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg + TW'(1);
    idx_next   = idx_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    req_next   = req_reg;

    // Acknowledge first so that a load on the same edge overrides it.
    if (req_reg && RCV_ACK) begin
      req_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (!line) begin
          state_next = START;
        end
      end
      START: begin
        if (timer_reg == TW'(CLKS_PER_BIT / 2 - 1)) begin
          timer_next = '0;
          idx_next   = '0;
          state_next = line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_reg == TW'(CLKS_PER_BIT - 1)) begin
          timer_next          = '0;
          shift_next[idx_reg] = line;
          if (idx_reg == IW'(DATA_BITS - 1)) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end
      end
      STOP: begin
        if (timer_reg == TW'(CLKS_PER_BIT - 1)) begin
          timer_next = '0;
          if (line) begin
            data_next  = shift_reg;
            req_next   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        timer_next = '0;
        if (line) begin
          state_next = IDLE;
        end
      end
      default: begin
        timer_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign RCV_REQ  = req_reg;
  assign RCV_DATA = data_reg;

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: table of frames plus hand sequences for glitch and reset.
module tb_receiver;

  logic       clk = 1'b0;
  logic       clr;
  logic       RCV;
  logic       RCV_ACK;
  logic       RCV_REQ;
  logic [7:0] RCV_DATA;

  int checks = 0;
  int errors = 0;
  int rise_cyc;
  int high_cnt;
  logic [7:0] model_data;

  receiver #(.CLKS_PER_BIT(8), .DATA_BITS(8)) dut (
    .clk      (clk),
    .clr      (clr),
    .RCV      (RCV),
    .RCV_ACK  (RCV_ACK),
    .RCV_REQ  (RCV_REQ),
    .RCV_DATA (RCV_DATA)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         ack_mode;   // 0 none, 1 ack only on the load edge, 2 ack held all frame
    bit         pre_ack;
    int         gap;
    logic       exp_req;
    logic [7:0] exp_data;
    bit         chk_lat;
    int         exp_pulses; // -1 = not checked
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_mode);
    logic [9:0] fr;
    logic prev;
    int cyc;
    fr = {stop, d, 1'b0};
    prev = RCV_REQ;
    cyc = 0;
    rise_cyc = -1;
    high_cnt = 0;
    if (ack_mode == 2) RCV_ACK = 1'b1;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 8; c++) begin
        RCV = fr[i];
        if (ack_mode == 1) RCV_ACK = (cyc == 78);
        @(posedge clk);
        #1;
        cyc++;
        if (RCV_REQ && !prev) rise_cyc = cyc;
        if (RCV_REQ) high_cnt++;
        prev = RCV_REQ;
      end
    end
    RCV = 1'b1;
    RCV_ACK = 1'b0;
  endtask

  task automatic do_ack();
    chk("req_before_ack", RCV_REQ, 1);
    RCV_ACK = 1'b1;
    tick(1);
    chk("req_after_ack", RCV_REQ, 0);
    chk("data_after_ack", RCV_DATA, model_data);
    RCV_ACK = 1'b0;
    tick(1);
  endtask

  initial begin
    vecs[0] = '{8'h61, 1'b1, 0, 1'b0, 4, 1'b1, 8'h61, 1'b1, -1};
    vecs[1] = '{8'hA5, 1'b1, 0, 1'b1, 4, 1'b1, 8'hA5, 1'b1, -1};
    vecs[2] = '{8'h55, 1'b0, 0, 1'b1, 4, 1'b0, 8'hA5, 1'b0, 0};
    vecs[3] = '{8'h0F, 1'b1, 0, 1'b0, 4, 1'b1, 8'h0F, 1'b1, -1};
    vecs[4] = '{8'h3C, 1'b1, 0, 1'b0, 4, 1'b1, 8'h3C, 1'b0, -1};
    vecs[5] = '{8'h12, 1'b1, 0, 1'b1, 0, 1'b1, 8'h12, 1'b1, -1};
    vecs[6] = '{8'h34, 1'b1, 0, 1'b0, 4, 1'b1, 8'h34, 1'b0, -1};
    vecs[7] = '{8'hC3, 1'b1, 1, 1'b0, 4, 1'b1, 8'hC3, 1'b0, -1};
    vecs[8] = '{8'h7E, 1'b1, 2, 1'b0, 4, 1'b0, 8'h7E, 1'b0, 1};

    clr = 1'b1;
    RCV = 1'b1;
    RCV_ACK = 1'b0;
    model_data = 8'h00;
    tick(3);
    chk("reset_req", RCV_REQ, 0);
    chk("reset_data", RCV_DATA, 0);
    clr = 1'b0;
    tick(4);

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].pre_ack) do_ack();
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].ack_mode);
      model_data = vecs[v].exp_data;
      $display("frame %0d: sent 0x%02h stop=%0b -> REQ=%0b DATA=0x%02h rise_cyc=%0d",
               v, vecs[v].data, vecs[v].stop, RCV_REQ, RCV_DATA, rise_cyc);
      chk($sformatf("v%0d_req", v), RCV_REQ, vecs[v].exp_req);
      chk($sformatf("v%0d_data", v), RCV_DATA, vecs[v].exp_data);
      if (vecs[v].chk_lat)
        chk($sformatf("v%0d_latency_ok", v), int'(rise_cyc >= 76 && rise_cyc <= 80), 1);
      if (vecs[v].exp_pulses >= 0)
        chk($sformatf("v%0d_req_high_cycles", v), high_cnt, vecs[v].exp_pulses);
      tick(vecs[v].gap);
    end

    // Two-cycle low glitch must be rejected in START.
    RCV = 1'b0;
    tick(2);
    RCV = 1'b1;
    tick(30);
    $display("glitch: REQ=%0b DATA=0x%02h", RCV_REQ, RCV_DATA);
    chk("glitch_req", RCV_REQ, 0);
    chk("glitch_data", RCV_DATA, model_data);
    send_frame(8'h3C, 1'b1, 0);
    model_data = 8'h3C;
    $display("frame after glitch: REQ=%0b DATA=0x%02h", RCV_REQ, RCV_DATA);
    chk("post_glitch_req", RCV_REQ, 1);
    chk("post_glitch_data", RCV_DATA, 8'h3C);
    chk("post_glitch_latency_ok", int'(rise_cyc >= 76 && rise_cyc <= 80), 1);
    tick(4);

    // Reset in the middle of the data bits of 0xFF.
    RCV = 1'b0;
    tick(8);
    RCV = 1'b1;
    tick(20);
    #2 clr = 1'b1;
    #1;
    $display("clr mid-frame: REQ=%0b DATA=0x%02h", RCV_REQ, RCV_DATA);
    chk("clr_req", RCV_REQ, 0);
    chk("clr_data", RCV_DATA, 0);
    tick(2);
    clr = 1'b0;
    tick(60);
    chk("after_clr_req", RCV_REQ, 0);
    chk("after_clr_data", RCV_DATA, 0);
    send_frame(8'h81, 1'b1, 0);
    $display("frame after clr: REQ=%0b DATA=0x%02h", RCV_REQ, RCV_DATA);
    chk("post_clr_req", RCV_REQ, 1);
    chk("post_clr_data", RCV_DATA, 8'h81);
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
